// File: rtl/park_pkg.sv
// Shared types, widths and arithmetic helpers for the parking session controller.
package park_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PRICE_W = 2;
  localparam int unsigned UNIT_W  = 4;
  localparam int unsigned FEE_W   = 6;
  localparam int unsigned SUM_W   = CNT_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BROWSE = 3'd1,
    ST_PARKED = 3'd2,
    ST_BILL   = 3'd3
  } state_t;

  localparam logic [2:0] LOT_NONE = 3'd0;
  localparam logic [2:0] LOT_A    = 3'd1;
  localparam logic [2:0] LOT_B    = 3'd2;

  // Fee is start + add*units; 3 + 3*15 = 48 fits in FEE_W bits.
  function automatic logic [FEE_W-1:0] calc_fee(
    input logic [PRICE_W-1:0] start,
    input logic [PRICE_W-1:0] add,
    input logic [UNIT_W-1:0]  units
  );
    return FEE_W'(start) + FEE_W'(add) * FEE_W'(units);
  endfunction

  // Apply up to two increments and two decrements, clamped to [0, total].
  function automatic logic [CNT_W-1:0] next_left(
    input logic [CNT_W-1:0] left,
    input logic [1:0]       inc,
    input logic [1:0]       dec,
    input logic [CNT_W-1:0] total
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(left) + SUM_W'(inc);
    if (sum < SUM_W'(dec)) return '0;
    sum = sum - SUM_W'(dec);
    if (sum > SUM_W'(total)) return total;
    return CNT_W'(sum);
  endfunction

endpackage

// File: rtl/park_bill_timer.sv
// Billing timer: divides clk into billing units and counts them, saturating at 15.
module park_bill_timer
  import park_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic              tick_c,
  output logic [UNIT_W-1:0] units
);

  localparam int unsigned CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CYC_W-1:0] cyc_q;

  assign tick_c = en && (cyc_q == CYC_W'(TICK_DIV - 1));

  // Clock-enable divider; clear restarts a full unit period.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc_q <= '0;
    end else if (en) begin
      cyc_q <= tick_c ? '0 : cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      units <= '0;
    end else if (tick_c && (units != '1)) begin
      units <= units + UNIT_W'(1);
    end
  end

endmodule

// File: rtl/park_session_ctrl.sv
// Session FSM, lot occupancy and billing for the parking-lot display path.
module park_session_ctrl
  import park_pkg::*;
#(
  parameter int unsigned TOTAL_A  = 5,
  parameter int unsigned TOTAL_B  = 7,
  parameter int unsigned START_A  = 2,
  parameter int unsigned START_B  = 3,
  parameter int unsigned ADD_A    = 1,
  parameter int unsigned ADD_B    = 2,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_a,
  input  logic               sel_b,
  input  logic               confirm,
  input  logic               cancel,
  input  logic               leave,
  input  logic               ext_in_a,
  input  logic               ext_in_b,
  input  logic               ext_out_a,
  input  logic               ext_out_b,
  output logic [2:0]         current,
  output logic [CNT_W-1:0]   total_a,
  output logic [CNT_W-1:0]   total_b,
  output logic [CNT_W-1:0]   left_a,
  output logic [CNT_W-1:0]   left_b,
  output logic [PRICE_W-1:0] price_start_a,
  output logic [PRICE_W-1:0] price_start_b,
  output logic [PRICE_W-1:0] price_add_a,
  output logic [PRICE_W-1:0] price_add_b,
  output logic [2:0]         state,
  output logic [UNIT_W-1:0]  units,
  output logic [FEE_W-1:0]   fee,
  output logic               fee_valid,
  output logic               reject
);

  assign total_a       = CNT_W'(TOTAL_A);
  assign total_b       = CNT_W'(TOTAL_B);
  assign price_start_a = PRICE_W'(START_A);
  assign price_start_b = PRICE_W'(START_B);
  assign price_add_a   = PRICE_W'(ADD_A);
  assign price_add_b   = PRICE_W'(ADD_B);

  state_t             state_q, state_d;
  logic [2:0]         current_d;
  logic [FEE_W-1:0]   fee_d;
  logic               fee_valid_d;
  logic               reject_d;
  logic               enter_a, enter_b, leave_a, leave_b;
  logic               tmr_clr, tmr_en, tick;
  logic [UNIT_W-1:0]  fee_units;
  logic [CNT_W-1:0]   cur_left;
  logic [PRICE_W-1:0] cur_start, cur_add;

  assign tmr_en = (state_q == ST_PARKED);

  park_bill_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tick_c (tick),
    .units  (units)
  );

  // A leave coinciding with a tick bills the already-incremented count.
  assign fee_units = (tick && (units != '1)) ? units + UNIT_W'(1) : units;

  assign cur_left  = (current == LOT_A) ? left_a        : left_b;
  assign cur_start = (current == LOT_A) ? price_start_a : price_start_b;
  assign cur_add   = (current == LOT_A) ? price_add_a   : price_add_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      current   <= LOT_NONE;
      fee       <= '0;
      fee_valid <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state_q   <= state_d;
      current   <= current_d;
      fee       <= fee_d;
      fee_valid <= fee_valid_d;
      reject    <= reject_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    current_d = current;
    fee_d     = fee;
    reject_d  = 1'b0;
    enter_a   = 1'b0;
    enter_b   = 1'b0;
    leave_a   = 1'b0;
    leave_b   = 1'b0;
    tmr_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        current_d = LOT_NONE;
        if (sel_a) begin
          state_d   = ST_BROWSE;
          current_d = LOT_A;
        end else if (sel_b) begin
          state_d   = ST_BROWSE;
          current_d = LOT_B;
        end
      end
      ST_BROWSE: begin
        if (confirm) begin
          if (cur_left != '0) begin
            state_d = ST_PARKED;
            tmr_clr = 1'b1;
            enter_a = (current == LOT_A);
            enter_b = (current == LOT_B);
          end else begin
            reject_d = 1'b1;
          end
        end else if (cancel) begin
          state_d   = ST_IDLE;
          current_d = LOT_NONE;
        end else if (sel_a) begin
          current_d = LOT_A;
        end else if (sel_b) begin
          current_d = LOT_B;
        end
      end
      ST_PARKED: begin
        if (leave) begin
          state_d = ST_BILL;
          fee_d   = calc_fee(cur_start, cur_add, fee_units);
          leave_a = (current == LOT_A);
          leave_b = (current == LOT_B);
        end
      end
      ST_BILL: begin
        if (confirm) begin
          state_d   = ST_IDLE;
          current_d = LOT_NONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        current_d = LOT_NONE;
      end
    endcase
    fee_valid_d = (state_d == ST_BILL);
  end

  // Occupancy tracks external traffic in every state plus the session car.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_a <= CNT_W'(TOTAL_A);
      left_b <= CNT_W'(TOTAL_B);
    end else begin
      left_a <= next_left(left_a, 2'(ext_out_a) + 2'(leave_a),
                          2'(ext_in_a) + 2'(enter_a), total_a);
      left_b <= next_left(left_b, 2'(ext_out_b) + 2'(leave_b),
                          2'(ext_in_b) + 2'(enter_b), total_b);
    end
  end

endmodule

// File: doc/park_session_ctrl.md
# park_session_ctrl

Upstream session controller for the parking-lot display path. Turns debounced button pulses into the lot selection, occupancy and tariff values that the pre-entry scrolling display consumes (`current`, `total_*`, `left_*`, `price_*`). Tracks one driver session at a time: browse a lot, enter, park, leave and bill. It also maintains occupancy of lots A and B against external car arrivals and departures.

## Interface
Parameters:
- TOTAL_A, 5: capacity of lot A (1..7).
- TOTAL_B, 7: capacity of lot B (1..7).
- START_A / START_B, 2 / 3: start price per lot (0..3).
- ADD_A / ADD_B, 1 / 2: price per billing unit per lot (0..3).
- TICK_DIV, 100_000_000: clk cycles per billing unit.

Ports (all input pulses are one clk wide, synchronous, already debounced):
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sel_a, sel_b  in  1  choose lot A / lot B.
- confirm  in  1  enter selected lot, or acknowledge bill.
- cancel  in  1  abandon browse.
- leave  in  1  session car leaves.
- ext_in_a, ext_in_b, ext_out_a, ext_out_b  in  1  other cars entering/leaving.
- current  out  3  0 none, 1 lot A, 2 lot B.
- total_a, total_b, left_a, left_b  out  3  capacity / free slots.
- price_start_a, price_start_b, price_add_a, price_add_b  out  2  tariff.
- state  out  3  FSM state code.
- units  out  4  elapsed billing units.
- fee  out  6  bill amount.
- fee_valid  out  1  high while in BILL.
- reject  out  1  one-cycle pulse on refused entry.

## Operation
- FSM states: IDLE=0, BROWSE=1, PARKED=2, BILL=3.
- IDLE:
  - current=0.
  - sel_a -> BROWSE with current=1; else sel_b -> BROWSE with current=2.
- BROWSE, priority confirm > cancel > sel:
  - confirm with left of current lot > 0: that lot's left decrements, units=0, -> PARKED.
  - confirm with left = 0: reject pulses, stay in BROWSE.
  - cancel -> IDLE, current=0.
  - sel_a/sel_b re-selects the lot (sel_a wins if both).
- PARKED:
  - current held.
  - Billing timer runs; units increments every TICK_DIV cycles and saturates at 15.
  - leave -> BILL. fee = START + ADD*units of current lot, at 6 bits (max 3+3*15=48). The lot's left increments.
- BILL:
  - fee, fee_valid=1 and current held.
  - confirm -> IDLE, fee_valid=0; fee keeps its last value.
- Occupancy, per lot, every cycle:
  - left_next = left − dec + inc.
  - dec = ext_in | session confirm-enter.
  - inc = ext_out | session leave.
  - Simultaneous inc and dec of the same lot: net change 0.
  - Two increments in one cycle count as two, clamped to TOTAL.
  - Two decrements in one cycle, or a decrement at 0, clamp at 0. The session enter is never accepted when left=0.
- total_*, price_* outputs are constant parameter values.

## Timing
- All outputs are registered and update on the clk edge after the triggering pulse.
- Reset values: state=IDLE, current=0, left_a=TOTAL_A, left_b=TOTAL_B, units=0, fee=0, fee_valid=0, reject=0.
- rst mid-session (any state) returns to these values in one cycle. No fee is produced.
- Billing timer:
  - Clears to 0 on the cycle PARKED is entered.
  - The first units increment occurs TICK_DIV cycles later.
  - The timer is a clock enable on clk; no derived clock.
- leave on the same cycle as a units increment: the fee uses the already-incremented units.
- Pulses not valid in the current state are ignored (e.g. leave in BROWSE, confirm in IDLE).
- ext_* pulses are honoured in every state.

## Structure
- Package park_pkg holds:
  - state enum.
  - lot codes LOT_NONE/LOT_A/LOT_B.
  - width constants: CNT_W=3, PRICE_W=2, UNIT_W=4, FEE_W=6.
- Sub-module park_bill_timer contains:
  - cycle counter with clear and enable, and tick output.
  - saturating 4-bit units counter.
- The FSM, occupancy arithmetic and fee multiply stay in the top.

## Test plan
- Reset, then sel_b, then confirm -> current=2, state=PARKED, left_b 7->6 one cycle after confirm.
- TICK_DIV=4, park in A, wait 12 cycles, leave -> units=3, fee=2+1*3=5, fee_valid=1, left_a restored to 5. Confirm -> IDLE, current=0.
- Five ext_in_a pulses to fill A, then sel_a, confirm -> reject pulses once, state stays BROWSE, left_a=0. Then ext_out_a, confirm -> PARKED, left_a=0.
- ext_in_b and ext_out_b on the same cycle at left_b=7 -> left_b stays 7. ext_out_b alone at 7 -> stays 7.
- TICK_DIV=2, park 40 cycles in B -> units saturates at 15, fee=3+2*15=33.
- rst asserted while PARKED -> next cycle state=IDLE, current=0, left_a=5, left_b=7, units=0.
